blk_c5055d: RTL and testbench

K -- requirements
Module: k

---
 rtl/blk_c5055d.sv | 142 ++++++++++++++
 tb/tb_blk_c5055d.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/blk_c5055d.sv
// rtl/blk_c5055d.sv - byte FIFO buffer with drop accounting for a non-stalling upstream
//
// Purpose:
//   DEPTH-entry circular buffer between a producer that cannot stall and a
//   consumer with ready/valid handshaking. Bytes arriving while the buffer is
//   full are discarded. Each discarded byte sets a sticky overflow flag and
//   increments a saturating drop counter.
//
// Ports:
//   clk        in   single rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   upstream byte present this cycle
//   in_data    in   upstream byte [WIDTH]
//   in_ready   out  buffer can accept a byte (level < DEPTH)
//   out_valid  out  out_data holds the oldest stored byte (level != 0)
//   out_data   out  head-of-buffer byte [WIDTH]
//   out_ready  in   consumer takes the head byte this cycle
//   level      out  occupancy 0..DEPTH [$clog2(DEPTH)+1]
//   ovf        out  sticky: at least one byte was dropped
//   drop_cnt   out  saturating count of dropped bytes [8]
//   ovf_clr    in   synchronous clear of ovf and drop_cnt

module blk_c5055d #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  output logic [7:0]                 drop_cnt,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic push;
  logic pop;
  logic drop;

  // Handshake status comes straight from the level register, so an
  // asynchronous reset is visible on these outputs before any clock edge.
  assign in_ready  = (level_q != FULL_LEVEL);
  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_cnt_q;

  // A drop is judged on this cycle's in_ready, so a pop in the same cycle
  // does not make room for the incoming byte.
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign drop = in_valid && !in_ready;

  always_comb begin
    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
    end
  end

  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (ovf_clr) begin
      // A drop coinciding with the clear is counted as the first drop
      // after the clear instead of being lost.
      ovf_d      = drop;
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is not reset; clearing level and pointers makes any old
  // contents unreachable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_blk_c5055d.sv
// tb/tb_blk_c5055d.sv - directed self-checking bench for blk_c5055d

module tb_blk_c5055d;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] level;
  logic       ovf;
  logic [7:0] drop_cnt;
  logic       ovf_clr;

  int n_cmp = 0;
  int n_bad = 0;

  blk_c5055d #(.DEPTH(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mixed push/pop pattern: 10 pushes and 10 pops, ending empty.
  logic iv_tab [16] = '{1,1,1,0,1,1,1,0,1,1,0,1,1,0,0,0};
  logic or_tab [16] = '{0,0,1,1,1,0,0,1,1,1,1,0,1,1,1,0};
  logic [2:0] lvl_tab [16] = '{3'd1,3'd2,3'd2,3'd1,3'd1,3'd2,3'd3,3'd2,
                               3'd2,3'd2,3'd1,3'd2,3'd2,3'd1,3'd0,3'd0};

  initial begin
    logic [7:0] model_q [$];
    logic [7:0] nxt;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    #2;
    check("rst_level",    {29'd0, level}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_ovf",      {31'd0, ovf}, 32'd0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    step();
    rst = 1'b0;

    // Single byte in, then out.
    in_valid = 1'b1; in_data = 8'h33;
    step();
    in_valid = 1'b0;
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_data",  {24'd0, out_data}, 32'h33);
    check("single_level", {29'd0, level}, 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_pop_level", {29'd0, level}, 32'd0);
    check("single_pop_valid", {31'd0, out_valid}, 32'd0);

    // Push into empty buffer with out_ready high: no pop that cycle.
    in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("empty_push_level", {29'd0, level}, 32'd1);
    check("empty_push_data",  {24'd0, out_data}, 32'h5A);
    step();
    out_ready = 1'b0;
    check("empty_push_drain", {29'd0, level}, 32'd0);

    // Fill and overflow.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'h31 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    check("fill_level",    {29'd0, level}, 32'd4);
    check("fill_in_ready", {31'd0, in_ready}, 32'd0);
    check("fill_ovf",      {31'd0, ovf}, 32'd1);
    check("fill_drop_cnt", {24'd0, drop_cnt}, 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_%0d", i), {24'd0, out_data}, 32'h31 + 32'(i));
      step();
    end
    out_ready = 1'b0;
    check("drain_level", {29'd0, level}, 32'd0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("clr_ovf",      {31'd0, ovf}, 32'd0);
    check("clr_drop_cnt", {24'd0, drop_cnt}, 32'd0);

    // Streaming: level settles at 1, order preserved.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(i);
      if (i > 0) check($sformatf("stream_data_%0d", i), {24'd0, out_data}, 32'(i - 1));
      step();
      check($sformatf("stream_level_%0d", i), {29'd0, level}, 32'd1);
    end
    in_valid = 1'b0;
    check("stream_last", {24'd0, out_data}, 32'h0F);
    step();
    out_ready = 1'b0;
    check("stream_empty", {29'd0, level}, 32'd0);
    check("stream_ovf",   {31'd0, ovf}, 32'd0);

    // Wrap-around with mixed push/pop.
    nxt = 8'h40;
    for (int c = 0; c < 16; c++) begin
      in_valid  = iv_tab[c];
      out_ready = or_tab[c];
      in_data   = nxt;
      if (or_tab[c]) begin
        check($sformatf("wrap_data_%0d", c), {24'd0, out_data}, {24'd0, model_q[0]});
        void'(model_q.pop_front());
      end
      if (iv_tab[c]) begin
        model_q.push_back(nxt);
        nxt = nxt + 8'd1;
      end
      step();
      check($sformatf("wrap_level_%0d", c), {29'd0, level}, {29'd0, lvl_tab[c]});
    end
    in_valid = 1'b0; out_ready = 1'b0;

    // Saturating drop counter.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'h50 + 8'(i);
      step();
    end
    in_data = 8'hEE;
    repeat (300) step();
    check("sat_drop_cnt", {24'd0, drop_cnt}, 32'd255);
    check("sat_ovf",      {31'd0, ovf}, 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("clr_drop_ovf", {31'd0, ovf}, 32'd1);
    check("clr_drop_cnt1", {24'd0, drop_cnt}, 32'd1);
    check("clr_keeps_level", {29'd0, level}, 32'd4);

    // Drop while popping in the same cycle.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    check("droppop_level", {29'd0, level}, 32'd3);
    check("droppop_cnt",   {24'd0, drop_cnt}, 32'd2);
    check("droppop_head",  {24'd0, out_data}, 32'h51);

    // Asynchronous reset between edges with level=3.
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_level",     {29'd0, level}, 32'd0);
    check("arst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("arst_ovf",       {31'd0, ovf}, 32'd0);
    check("arst_drop_cnt",  {24'd0, drop_cnt}, 32'd0);
    #1;
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h77;
    step();
    in_valid = 1'b0;
    check("post_rst_level", {29'd0, level}, 32'd1);
    check("post_rst_data",  {24'd0, out_data}, 32'h77);
    out_ready = 1'b1;
    step();
    check("post_rst_pop", {29'd0, level}, 32'd0);
    step();
    out_ready = 1'b0;
    check("post_rst_no_stale", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
